// File: rtl/ldst_pkg.sv
// Shared command types and line-address helper for the load/store command arbiter.
// Latency: n/a (types only). Backpressure: n/a.
package ldst_pkg;

    typedef enum logic [1:0] {
        SIZE_1B = 2'b00,
        SIZE_2B = 2'b01,
        SIZE_4B = 2'b10,
        SIZE_8B = 2'b11
    } ldst_size_e;

    typedef struct packed {
        logic [3:0]  block_id;
        logic [9:0]  tid;
        logic        write_enable;
        logic [63:0] write_data;
        logic [7:0]  write_mask;
        logic [63:0] address;
        ldst_size_e  size;
        logic [6:0]  ld_dest_reg;
    } ldst_cmd_t;

    function automatic logic [63:0] line_addr(input logic [63:0] addr, input int unsigned line_bits);
        return addr >> line_bits;
    endfunction

endpackage

// File: rtl/ldst_cmd_arbiter_if.sv
// Requester-side and coalescer-side handshake bundle of the load/store command arbiter.
// Latency: n/a (wiring). Backpressure: req_ready per requester, out_ready from the coalescer.
interface ldst_cmd_arbiter_if #(
    parameter int N_REQ = 4
);
    localparam int IDW = $clog2(N_REQ);

    logic [N_REQ-1:0]        req_valid;
    logic [N_REQ-1:0]        req_ready;
    logic [N_REQ-1:0][3:0]   req_block_id;
    logic [N_REQ-1:0][9:0]   req_tid;
    logic [N_REQ-1:0]        req_write_enable;
    logic [N_REQ-1:0][63:0]  req_write_data;
    logic [N_REQ-1:0][7:0]   req_write_mask;
    logic [N_REQ-1:0][63:0]  req_address;
    logic [N_REQ-1:0][1:0]   req_size;
    logic [N_REQ-1:0][6:0]   req_ld_dest_reg;

    logic                    out_valid;
    logic                    out_ready;
    logic [3:0]              out_block_id;
    logic [9:0]              out_tid;
    logic                    out_write_enable;
    logic [63:0]             out_write_data;
    logic [7:0]              out_write_mask;
    logic [63:0]             out_address;
    logic [1:0]              out_size;
    logic [6:0]              out_ld_dest_reg;
    logic [IDW-1:0]          out_req_id;

    modport master (
        input  req_valid, req_block_id, req_tid, req_write_enable, req_write_data,
               req_write_mask, req_address, req_size, req_ld_dest_reg, out_ready,
        output req_ready, out_valid, out_block_id, out_tid, out_write_enable,
               out_write_data, out_write_mask, out_address, out_size, out_ld_dest_reg,
               out_req_id
    );

    modport slave (
        output req_valid, req_block_id, req_tid, req_write_enable, req_write_data,
               req_write_mask, req_address, req_size, req_ld_dest_reg, out_ready,
        input  req_ready, out_valid, out_block_id, out_tid, out_write_enable,
               out_write_data, out_write_mask, out_address, out_size, out_ld_dest_reg,
               out_req_id
    );

endinterface

// File: rtl/ldst_rr_pick.sv
// Round-robin picker: first valid requester at or after start_i, wrapping modulo N_REQ.
// Latency: combinational. Backpressure: none; grant_o is all-zero when nothing is valid.
module ldst_rr_pick #(
    parameter int N_REQ = 4
) (
    input  logic [N_REQ-1:0]         valid_i,
    input  logic [$clog2(N_REQ)-1:0] start_i,
    output logic [N_REQ-1:0]         grant_o,
    output logic [$clog2(N_REQ)-1:0] idx_o,
    output logic                     any_o
);
    localparam int IDW = $clog2(N_REQ);

    always_comb begin
        int j;
        grant_o = '0;
        idx_o   = '0;
        any_o   = |valid_i;
        // Walk offsets from farthest to nearest so the nearest valid requester overwrites.
        for (int k = N_REQ - 1; k >= 0; k--) begin
            j = int'(start_i) + k;
            if (j >= N_REQ) j = j - N_REQ;
            if (valid_i[j]) idx_o = IDW'(j);
        end
        if (any_o) grant_o[idx_o] = 1'b1;
    end

endmodule

// File: rtl/ldst_cmd_arbiter.sv
// Round-robin arbiter feeding one registered command per cycle to the coalescer; optional sticky same-line policy (LDST_ARB_STICKY_EN).
// Latency: 1 cycle from accept to out_valid; full throughput with pop and load in the same cycle.
// Backpressure: out_valid && !out_ready holds the output stage and drops every req_ready.
module ldst_cmd_arbiter
    import ldst_pkg::*;
#(
    parameter int N_REQ           = 4,
    parameter int CACHE_LINE_SIZE = 32,
    parameter int MAX_BURST       = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    ldst_cmd_arbiter_if.master  bus
);
    localparam int IDW = $clog2(N_REQ);

    if (N_REQ < 2 || N_REQ > 16 || MAX_BURST < 1 || MAX_BURST > 255 || CACHE_LINE_SIZE < 8) begin : g_cfg_err
        $error("ldst_cmd_arbiter: unsupported parameter combination");
    end

    ldst_cmd_t          req_cmd [N_REQ];
    ldst_cmd_t          out_cmd_q, out_cmd_d;
    logic               out_valid_q, out_valid_d;
    logic [IDW-1:0]     out_id_q, out_id_d;
    logic [IDW-1:0]     rr_ptr_q, rr_ptr_d;

    logic [N_REQ-1:0]   rr_grant, win_oh, grant;
    logic [IDW-1:0]     rr_idx, win_idx;
    logic               rr_any, load_en, accept;

`ifdef LDST_ARB_STICKY_EN
    localparam int unsigned LINE_BITS = $clog2(CACHE_LINE_SIZE);

    logic [IDW-1:0]     last_id_q, last_id_d;
    logic [63:0]        last_line_q, last_line_d;
    logic               last_vld_q, last_vld_d;
    logic [7:0]         burst_cnt_q, burst_cnt_d;
    logic               sticky_hit;
    logic [N_REQ-1:0]   sticky_oh;
`endif

    always_comb begin
        for (int i = 0; i < N_REQ; i++) begin
            req_cmd[i] = '{
                block_id:     bus.req_block_id[i],
                tid:          bus.req_tid[i],
                write_enable: bus.req_write_enable[i],
                write_data:   bus.req_write_data[i],
                write_mask:   bus.req_write_mask[i],
                address:      bus.req_address[i],
                size:         ldst_size_e'(bus.req_size[i]),
                ld_dest_reg:  bus.req_ld_dest_reg[i]
            };
        end
    end

    ldst_rr_pick #(.N_REQ(N_REQ)) u_rr_pick (
        .valid_i (bus.req_valid),
        .start_i (rr_ptr_q),
        .grant_o (rr_grant),
        .idx_o   (rr_idx),
        .any_o   (rr_any)
    );

    always_comb begin
        load_en     = !out_valid_q || bus.out_ready;
        win_idx     = rr_idx;
        win_oh      = rr_grant;
        out_valid_d = out_valid_q;
        out_cmd_d   = out_cmd_q;
        out_id_d    = out_id_q;
        rr_ptr_d    = rr_ptr_q;
`ifdef LDST_ARB_STICKY_EN
        last_id_d   = last_id_q;
        last_line_d = last_line_q;
        last_vld_d  = last_vld_q;
        burst_cnt_d = burst_cnt_q;
        sticky_oh   = '0;
        sticky_oh[last_id_q] = 1'b1;
        // Stay on the previous winner while it keeps hitting the same line, up to the burst cap.
        sticky_hit  = last_vld_q && bus.req_valid[last_id_q]
                   && (line_addr(req_cmd[last_id_q].address, LINE_BITS) == last_line_q)
                   && (int'(burst_cnt_q) < MAX_BURST - 1);
        if (sticky_hit) begin
            win_idx = last_id_q;
            win_oh  = sticky_oh;
        end
`endif
        accept = load_en && rr_any;
        grant  = accept ? win_oh : '0;

        if (accept) begin
            out_valid_d = 1'b1;
            out_cmd_d   = req_cmd[win_idx];
            out_id_d    = win_idx;
            rr_ptr_d    = (win_idx == IDW'(N_REQ - 1)) ? '0 : win_idx + 1'b1;
`ifdef LDST_ARB_STICKY_EN
            last_id_d   = win_idx;
            last_line_d = line_addr(req_cmd[win_idx].address, LINE_BITS);
            last_vld_d  = 1'b1;
            burst_cnt_d = sticky_hit ? burst_cnt_q + 8'd1 : 8'd0;
            if (sticky_hit) rr_ptr_d = rr_ptr_q;
`endif
        end else if (bus.out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            out_cmd_q   <= '0;
            out_id_q    <= '0;
            rr_ptr_q    <= '0;
        end else begin
            out_valid_q <= out_valid_d;
            out_cmd_q   <= out_cmd_d;
            out_id_q    <= out_id_d;
            rr_ptr_q    <= rr_ptr_d;
        end
    end

`ifdef LDST_ARB_STICKY_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_id_q   <= '0;
            last_line_q <= '0;
            last_vld_q  <= 1'b0;
            burst_cnt_q <= '0;
        end else begin
            last_id_q   <= last_id_d;
            last_line_q <= last_line_d;
            last_vld_q  <= last_vld_d;
            burst_cnt_q <= burst_cnt_d;
        end
    end
`endif

    // Requesters must never see an accept while the arbiter is held in reset.
    assign bus.req_ready        = grant & {N_REQ{rst_n}};
    assign bus.out_valid        = out_valid_q;
    assign bus.out_block_id     = out_cmd_q.block_id;
    assign bus.out_tid          = out_cmd_q.tid;
    assign bus.out_write_enable = out_cmd_q.write_enable;
    assign bus.out_write_data   = out_cmd_q.write_data;
    assign bus.out_write_mask   = out_cmd_q.write_mask;
    assign bus.out_address      = out_cmd_q.address;
    assign bus.out_size         = out_cmd_q.size;
    assign bus.out_ld_dest_reg  = out_cmd_q.ld_dest_reg;
    assign bus.out_req_id       = out_id_q;

endmodule
